// File: rtl/uart_tx_buffer_pkg.sv
// uart_tx_buffer_pkg: shared FSM encoding and default sizes for the UART transmit buffer.
package uart_tx_buffer_pkg;
  localparam int NB_DATA_DEF = 8;
  localparam int NB_ADDR_DEF = 2;
  localparam int DEPTH = 1 << NB_ADDR_DEF;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// sync_fifo: circular byte store with registered count/full/empty and a sticky drop flag.
module sync_fifo #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [NB_DATA-1:0] i_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [NB_ADDR:0]   o_count,
  output logic               o_overflow
);
  localparam int DEPTH = 1 << NB_ADDR;
  logic [NB_DATA-1:0] r_mem [DEPTH];
  logic [NB_ADDR-1:0] r_wptr, r_rptr;
  logic [NB_ADDR:0]   r_count, w_count_nxt;
  logic               r_full, r_empty, r_overflow, w_pop, w_push;
  // A pop in the same cycle frees a slot, so a push while full is still taken.
  always_comb begin
    w_pop       = i_pop && !r_empty;
    w_push      = i_push && (!r_full || w_pop);
    w_count_nxt = r_count + (NB_ADDR+1)'(w_push) - (NB_ADDR+1)'(w_pop);
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_wptr     <= r_wptr + NB_ADDR'(w_push);
      r_rptr     <= r_rptr + NB_ADDR'(w_pop);
      r_count    <= w_count_nxt;
      r_full     <= w_count_nxt == (NB_ADDR+1)'(DEPTH);
      r_empty    <= w_count_nxt == '0;
      r_overflow <= r_overflow || (i_push && !w_push);
    end
  end
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
  assign o_data     = r_mem[r_rptr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: queues result bytes and hands them one at a time to tx_uart.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_tx_done_tick,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_full,
  output logic               o_empty,
  output logic [NB_ADDR:0]   o_count,
  output logic               o_overflow
);
  state_t             r_state;
  logic               r_tx_start, r_busy, w_pop, w_empty;
  logic [NB_DATA-1:0] r_tx_data, w_fifo_data;
  assign w_pop = (r_state == IDLE) && !w_empty;
  sync_fifo #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_fifo (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_push    (i_push),
    .i_pop     (w_pop),
    .i_data    (i_data),
    .o_data    (w_fifo_data),
    .o_full    (o_full),
    .o_empty   (w_empty),
    .o_count   (o_count),
    .o_overflow(o_overflow)
  );
  // Done ticks only matter in WAIT_DONE; LOAD always lasts a single cycle.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (!w_empty) begin
          r_state    <= LOAD;
          r_tx_start <= 1'b1;
          r_tx_data  <= w_fifo_data;
          r_busy     <= 1'b1;
        end
        LOAD: begin
          r_state    <= WAIT_DONE;
          r_tx_start <= 1'b0;
        end
        WAIT_DONE: if (i_tx_done_tick) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = r_busy;
  assign o_empty    = w_empty;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: table vectors, corner sequences and random traffic against a queue-based model.
module tb_uart_tx_buffer;
  localparam int QDEPTH = 4;
  logic       i_clock, i_reset, i_push, i_tx_done_tick;
  logic [7:0] i_data;
  logic       o_tx_start, o_busy, o_full, o_empty, o_overflow;
  logic [7:0] o_tx_data;
  logic [2:0] o_count;

  uart_tx_buffer dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_push        (i_push),
    .i_data        (i_data),
    .i_tx_done_tick(i_tx_done_tick),
    .o_tx_start    (o_tx_start),
    .o_tx_data     (o_tx_data),
    .o_busy        (o_busy),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_count       (o_count),
    .o_overflow    (o_overflow)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    logic       push;
    logic [7:0] data;
    logic       done;
    logic       start;
    logic [7:0] txd;
    logic       busy;
    logic [2:0] count;
    logic       full;
    logic       ovf;
  } vec_t;
  vec_t vecs[11];

  int n_cmp = 0;
  int n_err = 0;

  // Reference: a byte queue plus "a frame is in flight, started age cycles ago".
  logic [7:0] q[$];
  bit         m_inflight, m_start, m_ovf;
  int         m_age;
  logic [7:0] m_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("start", o_tx_start, m_start);
    chk("tx_data", o_tx_data, m_data);
    chk("busy", o_busy, m_inflight);
    chk("count", o_count, q.size());
    chk("full", o_full, q.size() == QDEPTH);
    chk("empty", o_empty, q.size() == 0);
    chk("overflow", o_overflow, m_ovf);
  endtask

  task automatic model_clear();
    q.delete();
    m_inflight = 0;
    m_start    = 0;
    m_ovf      = 0;
    m_age      = 0;
    m_data     = 8'h00;
  endtask

  task automatic tick(input logic p, input logic [7:0] d, input logic dn);
    bit can_pop;
    i_push = p;
    i_data = d;
    i_tx_done_tick = dn;
    @(posedge i_clock);
    can_pop = !m_inflight && q.size() > 0;
    m_start = can_pop;
    if (can_pop) begin
      m_data     = q.pop_front();
      m_inflight = 1;
      m_age      = 0;
    end else if (m_inflight) begin
      if (dn && m_age >= 1) m_inflight = 0;
      else m_age++;
    end
    if (p) begin
      if (q.size() < QDEPTH) q.push_back(d);
      else m_ovf = 1;
    end
    #1;
    check_model();
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_push = 1'b0;
    i_tx_done_tick = 1'b0;
    #2;
    model_clear();
    check_model();
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic drain(input int cycles, input int period);
    for (int k = 0; k < cycles; k++) tick(1'b0, 8'h00, (k % period) == period - 1);
  endtask

  initial begin
    i_reset = 1'b1;
    i_push = 1'b0;
    i_data = 8'h00;
    i_tx_done_tick = 1'b0;
    vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h01, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 8'h01, 1'b1, 3'd3, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h01, 1'b1, 3'd4, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 8'h01, 1'b1, 3'd4, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 3'd4, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 8'hBB, 1'b0, 1'b1, 8'h02, 1'b1, 3'd4, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 3'd4, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 3'd4, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 3'd3, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 20; k++) tick(1'b0, 8'h00, 1'b0);
    chk("idle_empty", o_empty, 1'b1);
    chk("idle_txd", o_tx_data, 8'h00);
    tick(1'b1, 8'h3C, 1'b0);
    chk("lat_no_start_yet", o_tx_start, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    chk("lat_start", o_tx_start, 1'b1);
    chk("lat_data", o_tx_data, 8'h3C);
    for (int k = 0; k < 99; k++) tick(1'b0, 8'h00, 1'b0);
    chk("hold_data", o_tx_data, 8'h3C);
    chk("hold_busy", o_busy, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    chk("done_busy", o_busy, 1'b0);
    do_reset();
    for (int v = 0; v < 11; v++) begin
      tick(vecs[v].push, vecs[v].data, vecs[v].done);
      chk($sformatf("vec%0d_start", v), o_tx_start, vecs[v].start);
      chk($sformatf("vec%0d_txd", v), o_tx_data, vecs[v].txd);
      chk($sformatf("vec%0d_busy", v), o_busy, vecs[v].busy);
      chk($sformatf("vec%0d_count", v), o_count, vecs[v].count);
      chk($sformatf("vec%0d_full", v), o_full, vecs[v].full);
      chk($sformatf("vec%0d_ovf", v), o_overflow, vecs[v].ovf);
    end
    drain(40, 3);
    do_reset();
    for (int k = 1; k <= 5; k++) tick(1'b1, 8'(k), 1'b0);
    chk("fill_count", o_count, 3'd4);
    chk("fill_ovf", o_overflow, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h66, 1'b0);
    chk("coinc_count", o_count, 3'd4);
    chk("coinc_ovf", o_overflow, 1'b0);
    chk("coinc_data", o_tx_data, 8'h02);
    drain(40, 4);
    chk("coinc_drained", o_empty, 1'b1);
    do_reset();
    for (int k = 0; k < 4; k++) tick(1'b1, 8'hC0 + 8'(k), 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    chk("pre_rst_count", o_count, 3'd3);
    chk("pre_rst_busy", o_busy, 1'b1);
    do_reset();
    chk("post_rst_count", o_count, 3'd0);
    for (int k = 0; k < 20; k++) tick(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3000; k++)
      tick($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 5) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
